// File: rtl/sel4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester arbiter that drives a 4:1 selector.
package sel4_rr_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] sel_to_onehot(input logic [SELW-1:0] sel);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sel4_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the resource and the arbiter.
interface sel4_rr_arbiter_if;
    import sel4_rr_arbiter_pkg::*;

    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] lock_i;
    logic            done_i;
    logic [NREQ-1:0] grant_o;
    logic [SELW-1:0] sel_o;
    logic            busy_o;
    logic            timeout_o;

    modport master (
        output req_i, lock_i, done_i,
        input  grant_o, sel_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, lock_i, done_i,
        output grant_o, sel_o, busy_o, timeout_o
    );

endinterface

// File: rtl/sel4_rr_arbiter_rr_pick4.sv
// Combinational winner pick: first set request scanning upward from the pointer
// (round-robin) or from index 0 (fixed priority).
module sel4_rr_arbiter_rr_pick4
    import sel4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [SELW-1:0] i_ptr,
    input  logic            i_fixed,
    output logic            o_any,
    output logic [SELW-1:0] o_idx
);

    always_comb begin
        logic            w_found;
        logic [SELW-1:0] w_cand;
        w_found = 1'b0;
        w_cand  = '0;
        o_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = i_fixed ? SELW'(i) : i_ptr + SELW'(i);
            if (!w_found && i_req[w_cand]) begin
                o_idx   = w_cand;
                w_found = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/sel4_rr_arbiter.sv
// Round-robin / fixed-priority arbiter with lock, back-to-back handoff and a
// release watchdog; sel_o feeds the control input of the downstream 4:1 selector.
module sel4_rr_arbiter
    import sel4_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    sel4_rr_arbiter_if.slave bus
);

    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;

    logic            w_pick_any;
    logic [SELW-1:0] w_pick_idx;
    logic            w_b2b_any;
    logic [SELW-1:0] w_b2b_idx;
    logic [NREQ-1:0] w_b2b_req;
    logic            w_busy;
    logic            w_keep;
    logic            w_wd_fire;
    logic            w_release;
    logic            w_start;
    logic            w_handoff;
    logic [SELW-1:0] w_new_idx;

    // Fixed priority must be able to re-grant the same winner, so only the
    // round-robin handoff excludes the requester being released.
    assign w_b2b_req = FIXED_PRIO ? bus.req_i : (bus.req_i & ~r_grant);

    sel4_rr_arbiter_rr_pick4 u_pick_idle (
        .i_req   (bus.req_i),
        .i_ptr   (r_ptr),
        .i_fixed (FIXED_PRIO),
        .o_any   (w_pick_any),
        .o_idx   (w_pick_idx)
    );

    sel4_rr_arbiter_rr_pick4 u_pick_b2b (
        .i_req   (w_b2b_req),
        .i_ptr   (r_ptr),
        .i_fixed (FIXED_PRIO),
        .o_any   (w_b2b_any),
        .o_idx   (w_b2b_idx)
    );

    assign w_busy    = (r_state == ST_BUSY);
    assign w_keep    = bus.lock_i[r_sel] & bus.req_i[r_sel];
    // done_i outranks the watchdog, so a late completion never raises timeout_o.
    assign w_wd_fire = (TIMEOUT != 0) && (r_cnt == CW'(TLIM)) && !bus.done_i;
    assign w_release = w_busy && ((bus.done_i && !w_keep) || w_wd_fire);
    assign w_start   = !w_busy && w_pick_any;
    assign w_handoff = w_release && w_b2b_any;
    assign w_new_idx = w_start ? w_pick_idx : w_b2b_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_busy && w_wd_fire;
            if (w_start || w_handoff) begin
                r_state <= ST_BUSY;
                r_grant <= sel_to_onehot(w_new_idx);
                r_sel   <= w_new_idx;
                r_cnt   <= '0;
                if (!FIXED_PRIO) begin
                    r_ptr <= w_new_idx + 1'b1;
                end
            end else if (w_release) begin
                // sel_o keeps the last winner so the selector output stays stable.
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_cnt   <= '0;
            end else if (w_busy && bus.done_i) begin
                r_cnt <= '0;
            end else if (w_busy && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.grant_o   = r_grant;
    assign bus.sel_o     = r_sel;
    assign bus.busy_o    = w_busy;
    assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_sel4_rr_arbiter.sv
// Directed-vector bench: a round-robin instance (TIMEOUT=16) and a fixed-priority instance.
module tb_sel4_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    sel4_rr_arbiter_if if_rr ();
    sel4_rr_arbiter_if if_fp ();

    sel4_rr_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr.slave)
    );

    sel4_rr_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done_rr();
        if_rr.done_i = 1'b1;
        step();
        if_rr.done_i = 1'b0;
    endtask

    task automatic pulse_done_fp();
        if_fp.done_i = 1'b1;
        step();
        if_fp.done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_rr.req_i = '0; if_rr.lock_i = '0; if_rr.done_i = 1'b0;
        if_fp.req_i = '0; if_fp.lock_i = '0; if_fp.done_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] exp_g1 [4];
        logic [1:0] exp_s2 [5];
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b1;
        do_reset();

        chk("rst_grant",   32'(if_rr.grant_o),   32'h0);
        chk("rst_sel",     32'(if_rr.sel_o),     32'h0);
        chk("rst_busy",    32'(if_rr.busy_o),    32'h0);
        chk("rst_timeout", 32'(if_rr.timeout_o), 32'h0);

        // done_i while IDLE must be ignored.
        pulse_done_rr();
        chk("idle_done_busy", 32'(if_rr.busy_o), 32'h0);

        // 1. req 0101, done every 3rd cycle: 0,2,0,2 with no idle bubble.
        exp_g1 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        if_rr.req_i = 4'b0101;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_grant%0d", i), 32'(if_rr.grant_o), 32'(exp_g1[i]));
            chk($sformatf("t1_sel%0d", i),   32'(if_rr.sel_o),   (i % 2 == 0) ? 32'h0 : 32'h2);
            step();
            chk($sformatf("t1_busy%0d", i),  32'(if_rr.busy_o),  32'h1);
            step();
            pulse_done_rr();
        end

        // 2. req 1111: sel 0,1,2,3,0 with pointer wrap.
        do_reset();
        exp_s2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        if_rr.req_i = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_sel%0d", i),   32'(if_rr.sel_o),   32'(exp_s2[i]));
            chk($sformatf("t2_grant%0d", i), 32'(if_rr.grant_o), 32'(4'b0001 << exp_s2[i]));
            pulse_done_rr();
        end

        // 3. Lock holds requester 1 across done pulses; dropping lock hands off to 0.
        do_reset();
        if_rr.req_i = 4'b0010;
        step();
        chk("t3_first", 32'(if_rr.grant_o), 32'h2);
        if_rr.req_i  = 4'b0011;
        if_rr.lock_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            pulse_done_rr();
            chk($sformatf("t3_lock%0d", i), 32'(if_rr.grant_o), 32'h2);
        end
        if_rr.lock_i = 4'b0000;
        pulse_done_rr();
        chk("t3_handoff_grant", 32'(if_rr.grant_o), 32'h1);
        chk("t3_handoff_sel",   32'(if_rr.sel_o),   32'h0);

        // 4a. Watchdog: 16 BUSY cycles without done_i force a release.
        do_reset();
        if_rr.req_i = 4'b1000;
        step();
        if_rr.req_i = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("t4_busy_c%0d", k), 32'(if_rr.busy_o),    32'h1);
            chk($sformatf("t4_to0_c%0d", k),  32'(if_rr.timeout_o), 32'h0);
            if (k < 16) step();
        end
        step();
        chk("t4_rel_grant", 32'(if_rr.grant_o),   32'h0);
        chk("t4_pulse",     32'(if_rr.timeout_o), 32'h1);
        chk("t4_sel_hold",  32'(if_rr.sel_o),     32'h3);
        step();
        chk("t4_pulse_end", 32'(if_rr.timeout_o), 32'h0);
        chk("t4_idle",      32'(if_rr.busy_o),    32'h0);

        // 4b. done_i on the 16th cycle wins: release without timeout pulse.
        if_rr.req_i = 4'b1000;
        step();
        if_rr.req_i = 4'b0000;
        for (int k = 1; k < 16; k++) step();
        chk("t4b_busy16", 32'(if_rr.busy_o), 32'h1);
        pulse_done_rr();
        chk("t4b_grant", 32'(if_rr.grant_o),   32'h0);
        chk("t4b_nopls", 32'(if_rr.timeout_o), 32'h0);
        step();
        chk("t4b_nopls2", 32'(if_rr.timeout_o), 32'h0);

        // 5. Asynchronous reset between edges clears outputs immediately.
        do_reset();
        if_rr.req_i = 4'b0100;
        step();
        chk("t5_pre_grant", 32'(if_rr.grant_o), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(if_rr.grant_o), 32'h0);
        chk("t5_async_sel",   32'(if_rr.sel_o),   32'h0);
        chk("t5_async_busy",  32'(if_rr.busy_o),  32'h0);
        if_rr.req_i = 4'b0000;
        step();
        rst_n = 1'b1;
        if_rr.req_i = 4'b1000;
        step();
        chk("t5_grant3", 32'(if_rr.grant_o), 32'h8);
        chk("t5_sel3",   32'(if_rr.sel_o),   32'h3);

        // 6. Fixed priority: req 1110 held keeps re-granting requester 1.
        do_reset();
        if_fp.req_i = 4'b1110;
        step();
        chk("t6_first", 32'(if_fp.grant_o), 32'h2);
        for (int i = 0; i < 3; i++) begin
            pulse_done_fp();
            chk($sformatf("t6_grant%0d", i), 32'(if_fp.grant_o), 32'h2);
            chk($sformatf("t6_busy%0d", i),  32'(if_fp.busy_o),  32'h1);
        end
        if_fp.req_i = 4'b0000;
        pulse_done_fp();
        chk("t6_idle_busy",  32'(if_fp.busy_o),  32'h0);
        chk("t6_idle_grant", 32'(if_fp.grant_o), 32'h0);
        step();
        chk("t6_sel_hold",   32'(if_fp.sel_o),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
